dm_wt_cache: RTL and testbench
==============================

Name: dm_wt_cache

Overview:
- Direct-mapped, write-through, no-write-allocate word cache.
- Sits directly downstream of the AHB-lite SDRAM bridge and consumes its rd_en/wr_en pulse + busy request interface.
- Forwards misses and all writes to a backing-memory port (SDRAM controller side) through a req/ack handshake.
- Read hits complete in the request cycle, with no busy assertion.

Parameters:
- W_ADDR, 32, byte address width.
- W_DATA, 32, data width; fixed at 32 (4 byte lanes).
- N_LINES, 16, number of one-word lines; must be a power of 2, ≥2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- i_rd_en  in  1  read request pulse, sampled only in IDLE.
- i_wr_en  in  1  write request pulse, sampled only in IDLE.
- i_addr  in  W_ADDR  byte address; bits [1:0] are ignored.
- i_data  in  32  write data.
- i_mask  in  4  byte-lane write enables.
- o_data  out  32  read data.
- o_busy  out  1  high while a miss fill or write-through is in progress.
- o_hit  out  1  combinational; read hit served this cycle.
- o_state  out  2  FSM state: 00 IDLE, 01 FILL, 10 WRITE.
- m_rd_req  out  1  backing read request, level.
- m_wr_req  out  1  backing write request, level.
- m_addr  out  W_ADDR  backing word address, bits [1:0]=00.
- m_wdata  out  32  backing write data.
- m_mask  out  4  backing byte mask.
- m_rdata  in  32  backing read data, valid with m_ack.
- m_ack  in  1  one-cycle completion pulse.

Behaviour:
- Address split: IDX=log2(N_LINES). index=addr[2+IDX-1:2]; tag=addr[W_ADDR-1:2+IDX].
- Storage: per line a valid bit, a tag and a 32-bit data word. The arrays are registers and are read combinationally.
- Reset (synchronous, rst=1 at a clk edge):
  - All valid bits cleared; state IDLE.
  - o_busy, o_hit, m_rd_req and m_wr_req all 0; registered o_data=0, m_addr=0, m_wdata=0, m_mask=0.
  - Reset mid-FILL or mid-WRITE abandons the transaction with no array update. A later m_ack is ignored.
- o_busy = (state != IDLE). It is a registered state decode.
- IDLE, i_wr_en=1 (has priority if i_rd_en is also 1; the read is dropped):
  - Capture address, data and mask onto the m_* outputs.
  - Assert m_wr_req from the next cycle; go to WRITE.
  - On a hit (valid && tag match), merge the i_mask lanes of i_data into the line in the same edge.
  - On a miss, the array is unchanged (no allocate).
- IDLE, i_rd_en=1, hit:
  - o_hit=1 combinationally in the same cycle; o_data=line data in the same cycle.
  - The registered o_data is updated to the line data at the edge. State stays IDLE.
- IDLE, i_rd_en=1, miss:
  - o_hit=0; capture the word address.
  - Next cycle: state FILL, m_rd_req=1, o_busy=1.
- FILL:
  - Hold m_rd_req and m_addr stable until m_ack.
  - On m_ack at cycle A: write m_rdata into the line, set valid, set the tag, register o_data=m_rdata. m_rd_req drops at A+1.
  - State is IDLE at A+1, so o_busy=0 and o_data is valid at A+1.
- WRITE:
  - Hold m_wr_req, m_addr, m_wdata and m_mask stable until m_ack.
  - On m_ack, go to IDLE at the next cycle. o_data is unchanged.
- o_data mux: (state==IDLE && i_rd_en && hit) ? line data : registered o_data. The registered value holds between requests.
- Requests while busy: i_rd_en and i_wr_en are ignored. The producer must wait for o_busy=0.
- m_ack while IDLE: ignored.
- m_ack in the same cycle as the request is entered is impossible, because m_*_req is not yet high.
- Index aliasing: a fill evicts the prior line unconditionally. No write-back is needed (write-through).
- i_mask=0000 on a write: still forwarded; the line is unchanged.
- Latency: read hit 0 cycles. Read miss: backing latency + 2 cycles (request-register cycle, then ack-to-idle cycle). Write: backing latency + 2 cycles.

Test Plan:
- Reset, then read 0x0000_0040 with m_ack returning m_rdata=0xDEADBEEF 3 cycles after m_rd_req.
  - m_rd_req rises 1 cycle after i_rd_en, with m_addr=0x40.
  - o_busy falls and o_data=0xDEADBEEF the cycle after m_ack.
  - Re-reading 0x40 gives o_hit=1 and o_data=0xDEADBEEF in the same cycle, with o_busy staying 0.
- With 0x40 cached, write 0x40 with i_data=0x11223344 and i_mask=0011.
  - m_wr_req is issued with m_mask=0011.
  - After ack, a read of 0x40 hits with 0xDEAD3344.
- Write 0x80 (uncached), then read 0x80.
  - The read misses; no allocate occurred.
- Index alias with N_LINES=16: fill 0x40, then fill 0x80 (same index 0).
  - Reading 0x40 then misses and issues m_rd_req.
- i_rd_en and i_wr_en together on 0x40.
  - Only m_wr_req is issued.
  - Pulses on i_rd_en while o_busy=1 produce no extra m_* requests.
- Assert rst during FILL, then deliver m_ack.
  - o_busy=0 and m_rd_req=0 the cycle after rst.
  - No line becomes valid: a read of that address misses.

Source files
------------

// File: rtl/dm_wt_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache between the
// AHB-lite SDRAM bridge request interface and a req/ack backing-memory port.
module dm_wt_cache #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int N_LINES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [W_ADDR-1:0]     i_addr,
  input  logic [W_DATA-1:0]     i_data,
  input  logic [W_DATA/8-1:0]   i_mask,
  output logic [W_DATA-1:0]     o_data,
  output logic                  o_busy,
  output logic                  o_hit,
  output logic [1:0]            o_state,
  output logic                  m_rd_req,
  output logic                  m_wr_req,
  output logic [W_ADDR-1:0]     m_addr,
  output logic [W_DATA-1:0]     m_wdata,
  output logic [W_DATA/8-1:0]   m_mask,
  input  logic [W_DATA-1:0]     m_rdata,
  input  logic                  m_ack
);

  localparam int IDX   = $clog2(N_LINES);
  localparam int W_TAG = W_ADDR - 2 - IDX;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10
  } state_t;

  state_t             state, state_nxt;
  logic [N_LINES-1:0] valid;
  logic [W_TAG-1:0]   tags  [N_LINES];
  logic [W_DATA-1:0]  lines [N_LINES];
  logic [W_DATA-1:0]  o_data_r;

  logic [IDX-1:0]     idx_in, idx_m;
  logic [W_TAG-1:0]   tag_in, tag_m;
  logic               hit, rd_hit;
  logic               addr_lsb_unused;

  function automatic logic [W_DATA-1:0] merge_lanes(input logic [W_DATA-1:0]   old_w,
                                                    input logic [W_DATA-1:0]   new_w,
                                                    input logic [W_DATA/8-1:0] mask);
    logic [W_DATA-1:0] r;
    r = old_w;
    for (int b = 0; b < W_DATA/8; b++)
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign idx_in          = i_addr[2+IDX-1:2];
  assign tag_in          = i_addr[W_ADDR-1:2+IDX];
  assign idx_m           = m_addr[2+IDX-1:2];
  assign tag_m           = m_addr[W_ADDR-1:2+IDX];
  assign addr_lsb_unused = ^{i_addr[1:0], m_addr[1:0]};

  // A simultaneous write wins, so a read only counts as a hit when it is alone.
  assign hit    = valid[idx_in] && (tags[idx_in] == tag_in);
  assign rd_hit = (state == IDLE) && i_rd_en && !i_wr_en && hit;

  assign o_hit    = rd_hit;
  assign o_data   = rd_hit ? lines[idx_in] : o_data_r;
  assign o_busy   = (state != IDLE);
  assign o_state  = state;
  assign m_rd_req = (state == FILL);
  assign m_wr_req = (state == WRITE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_wr_en)              state_nxt = WRITE;
        else if (i_rd_en && !hit) state_nxt = FILL;
      end
      FILL:    if (m_ack) state_nxt = IDLE;
      WRITE:   if (m_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL && m_ack) valid[idx_m] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_r <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_mask   <= '0;
    end else if (state == IDLE) begin
      if (i_wr_en) begin
        m_addr  <= {i_addr[W_ADDR-1:2], 2'b00};
        m_wdata <= i_data;
        m_mask  <= i_mask;
      end else if (i_rd_en) begin
        if (hit) o_data_r <= lines[idx_in];
        else     m_addr   <= {i_addr[W_ADDR-1:2], 2'b00};
      end
    end else if (state == FILL && m_ack) begin
      o_data_r <= m_rdata;
    end
  end

  // Line storage is not reset; valid bits alone gate its use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && i_wr_en && hit) begin
        lines[idx_in] <= merge_lanes(lines[idx_in], i_data, i_mask);
      end else if (state == FILL && m_ack) begin
        lines[idx_m] <= m_rdata;
        tags[idx_m]  <= tag_m;
      end
    end
  end

endmodule

// File: tb/tb_dm_wt_cache.sv
// Bench for dm_wt_cache: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level cache/backing-memory model.
module tb_dm_wt_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rd_en, i_wr_en;
  logic [31:0] i_addr, i_data;
  logic [3:0]  i_mask;
  logic [31:0] o_data;
  logic        o_busy, o_hit;
  logic [1:0]  o_state;
  logic        m_rd_req, m_wr_req;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic [31:0] m_rdata;
  logic        m_ack;

  dm_wt_cache #(.W_ADDR(32), .W_DATA(32), .N_LINES(16)) dut (
    .clk(clk), .rst(rst), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask),
    .o_data(o_data), .o_busy(o_busy), .o_hit(o_hit), .o_state(o_state),
    .m_rd_req(m_rd_req), .m_wr_req(m_wr_req), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_mask(m_mask), .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int lat   = 3;
  bit chk_en = 1'b0;

  // Backing memory: words never written read back as an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Cache model: which word address each index holds. Write-through keeps
  // every valid line equal to backing memory, so hit data comes from mem.
  bit          lv [16];
  logic [31:0] la [16];
  int          mst;
  logic [31:0] maddr, mwdata, odata;
  logic [3:0]  mmask;

  function automatic logic [31:0] wa(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int i;
    i = int'((a >> 2) % 16);
    return lv[i] && (la[i] == wa(a));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) lv[i] = 1'b0;
      mst = 0; maddr = 0; mwdata = 0; mmask = 0; odata = 0;
      chk_en = 1'b1;
    end else begin
      case (mst)
        0: begin
          if (i_wr_en) begin
            maddr = wa(i_addr); mwdata = i_data; mmask = i_mask; mst = 2;
          end else if (i_rd_en) begin
            if (model_hit(i_addr)) odata = mem_rd(wa(i_addr));
            else begin maddr = wa(i_addr); mst = 1; end
          end
        end
        1: if (m_ack) begin
          lv[int'((maddr >> 2) % 16)] = 1'b1;
          la[int'((maddr >> 2) % 16)] = maddr;
          odata = mem_rd(maddr);
          mst = 0;
        end
        default: if (m_ack) begin
          mem[maddr] = merge(mem_rd(maddr), mwdata, mmask);
          mst = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_busy",   32'(o_busy),   32'(mst != 0));
      chk("o_state",  32'(o_state),  32'(mst));
      chk("m_rd_req", 32'(m_rd_req), 32'(mst == 1));
      chk("m_wr_req", 32'(m_wr_req), 32'(mst == 2));
      chk("m_addr",   m_addr,        maddr);
      chk("m_wdata",  m_wdata,       mwdata);
      chk("m_mask",   32'(m_mask),   32'(mmask));
      if (!(mst == 0 && i_rd_en && i_wr_en)) begin
        if (mst == 0 && i_rd_en && model_hit(i_addr)) begin
          chk("o_hit",  32'(o_hit), 32'd1);
          chk("o_data", o_data, mem_rd(wa(i_addr)));
        end else begin
          chk("o_hit",  32'(o_hit), 32'd0);
          chk("o_data", o_data, odata);
        end
      end
    end
  end

  // Backing responder: ack 'lat' cycles after a request is first seen.
  initial begin
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (m_rd_req || m_wr_req) begin
        repeat (lat) @(posedge clk);
        #1;
        m_ack = 1'b1;
        m_rdata = mem_rd(m_addr);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input bit junk, output int cyc);
    cyc = 0;
    while (o_busy && cyc < 60) begin
      if (junk) begin
        i_rd_en = 1'($urandom); i_wr_en = 1'($urandom); i_addr = $urandom;
      end
      step();
      cyc++;
    end
    i_rd_en = 1'b0; i_wr_en = 1'b0;
    if (o_busy) chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    step();
    i_addr = a; i_data = d; i_mask = m;
    if (wr) i_wr_en = 1'b1; else i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0; i_wr_en = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [31:0] a;
    rst = 1'b1; i_rd_en = 0; i_wr_en = 0; i_addr = 0; i_data = 0; i_mask = 0;
    mem[32'h40] = 32'hDEADBEEF;
    repeat (2) step();
    rst = 1'b0;
    #1;
    chk("rst_busy",  32'(o_busy),   32'd0);
    chk("rst_state", 32'(o_state),  32'd0);
    chk("rst_rdreq", 32'(m_rd_req), 32'd0);
    chk("rst_odata", o_data,        32'd0);

    // Cold read miss of 0x40, ack three cycles after the request rises.
    lat = 3;
    step(); i_addr = 32'h40; i_rd_en = 1'b1; #1;
    chk("miss_hit", 32'(o_hit), 32'd0);
    step(); i_rd_en = 1'b0; #1;
    chk("miss_rdreq", 32'(m_rd_req), 32'd1);
    chk("miss_addr",  m_addr,        32'h40);
    wait_idle(1'b0, cyc);
    chk("miss_cycles", 32'(cyc), 32'd4);
    chk("fill_data",   o_data,   32'hDEADBEEF);

    step(); i_addr = 32'h40; i_rd_en = 1'b1; #1;
    chk("rehit_hit",  32'(o_hit),  32'd1);
    chk("rehit_data", o_data,      32'hDEADBEEF);
    chk("rehit_busy", 32'(o_busy), 32'd0);
    step(); i_rd_en = 1'b0;

    // Partial write-through hit.
    issue(1'b1, 32'h40, 32'h11223344, 4'b0011); #1;
    chk("wr_req",  32'(m_wr_req), 32'd1);
    chk("wr_mask", 32'(m_mask),   32'h3);
    wait_idle(1'b0, cyc);
    chk("wr_cycles", 32'(cyc), 32'd4);
    step(); i_addr = 32'h40; i_rd_en = 1'b1; #1;
    chk("merge_hit",  32'(o_hit), 32'd1);
    chk("merge_data", o_data,     32'hDEAD3344);
    step(); i_rd_en = 1'b0;

    // Write miss does not allocate; the read of 0x80 also evicts 0x40.
    issue(1'b1, 32'h80, 32'hCAFEF00D, 4'b1111);
    wait_idle(1'b0, cyc);
    step(); i_addr = 32'h80; i_rd_en = 1'b1; #1;
    chk("noalloc_hit", 32'(o_hit), 32'd0);
    step(); i_rd_en = 1'b0; #1;
    chk("noalloc_rdreq", 32'(m_rd_req), 32'd1);
    wait_idle(1'b0, cyc);
    chk("wr_then_fill", o_data, 32'hCAFEF00D);
    step(); i_addr = 32'h40; i_rd_en = 1'b1; #1;
    chk("alias_hit", 32'(o_hit), 32'd0);
    step(); i_rd_en = 1'b0; #1;
    chk("alias_rdreq", 32'(m_rd_req), 32'd1);
    wait_idle(1'b0, cyc);

    // Read and write together, then reads while busy.
    step(); i_addr = 32'h40; i_data = 32'h0BADF00D; i_mask = 4'hF;
    i_rd_en = 1'b1; i_wr_en = 1'b1;
    step(); i_wr_en = 1'b0; i_addr = 32'h100; #1;
    chk("both_wrreq", 32'(m_wr_req), 32'd1);
    chk("both_rdreq", 32'(m_rd_req), 32'd0);
    step(); #1;
    chk("busy_rd_ignored", 32'(m_rd_req), 32'd0);
    step(); i_rd_en = 1'b0;
    wait_idle(1'b0, cyc);

    // Reset in the middle of a fill; the late ack must be dropped.
    issue(1'b0, 32'h1C0, 32'h0, 4'h0);
    step(); rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("rstfill_busy",  32'(o_busy),   32'd0);
    chk("rstfill_rdreq", 32'(m_rd_req), 32'd0);
    repeat (6) step();
    step(); i_addr = 32'h1C0; i_rd_en = 1'b1; #1;
    chk("rstfill_hit", 32'(o_hit), 32'd0);
    step(); i_rd_en = 1'b0; #1;
    chk("rstfill_rdreq2", 32'(m_rd_req), 32'd1);
    wait_idle(1'b0, cyc);

    // Randomized traffic over four tags per index.
    for (int t = 0; t < 400; t++) begin
      lat = $urandom_range(0, 4);
      a = {22'd0, 6'($urandom_range(0, 63)), 2'b00} | 32'($urandom_range(0, 3));
      issue(($urandom_range(0, 9) < 4), a, $urandom,
            ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom));
      wait_idle(($urandom_range(0, 2) == 0), cyc);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
